// File: rtl/cdr_pkg.sv
// Shared constants and phase-decision type for the clock/data recovery phase controller.
package cdr_pkg;

    localparam int NB_P_W   = 6;
    localparam int NB_P_NOM = 25;
    localparam int THRESH   = 4;
    localparam int ACC_W    = 4;

    typedef enum logic [1:0] {
        PD_NONE  = 2'd0,
        PD_EARLY = 2'd1,
        PD_LATE  = 2'd2
    } pd_dec_e;

endpackage

// File: rtl/cdr_loop_filter.sv
// Saturating early/late accumulator that selects the symbol period for the next symbol.
module cdr_loop_filter
    import cdr_pkg::*;
#(
    parameter int NB_P_NOM = cdr_pkg::NB_P_NOM,
    parameter int THRESH   = cdr_pkg::THRESH,
    parameter int ACC_W    = cdr_pkg::ACC_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  pd_dec_e           i_dec,
    input  logic              i_en_freq_synch,
    output logic [NB_P_W-1:0] o_nb_P
);

    localparam logic signed [ACC_W-1:0]  ACC_MAX = ACC_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  ACC_MIN = ACC_W'(-((2 ** (ACC_W - 1)) - 1));
    localparam logic signed [ACC_W-1:0]  THR_POS = ACC_W'(THRESH);
    localparam logic signed [ACC_W-1:0]  THR_NEG = ACC_W'(-THRESH);
    localparam logic signed [ACC_W-1:0]  ACC_ONE = ACC_W'(1);
    localparam logic [NB_P_W-1:0]        NB_NOM  = NB_P_W'(NB_P_NOM);
    localparam logic [NB_P_W-1:0]        NB_SLOW = NB_P_W'(NB_P_NOM + 1);
    localparam logic [NB_P_W-1:0]        NB_FAST = NB_P_W'(NB_P_NOM - 1);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_upd;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic [NB_P_W-1:0]       r_nb_p;
    logic [NB_P_W-1:0]       w_nb_p_nxt;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_acc_upd = r_acc;
        if (i_dec == PD_EARLY && r_acc != ACC_MAX) begin
            w_acc_upd = r_acc + ACC_ONE;
        end else if (i_dec == PD_LATE && r_acc != ACC_MIN) begin
            w_acc_upd = r_acc - ACC_ONE;
        end

        // Threshold sees the accumulator including this cycle's decision.
        w_acc_nxt  = w_acc_upd;
        w_nb_p_nxt = r_nb_p;
        if (i_en_freq_synch) begin
            if (w_acc_upd >= THR_POS) begin
                w_nb_p_nxt = NB_SLOW;
                w_acc_nxt  = '0;
            end else if (w_acc_upd <= THR_NEG) begin
                w_nb_p_nxt = NB_FAST;
                w_acc_nxt  = '0;
            end else begin
                w_nb_p_nxt = NB_NOM;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc  <= '0;
            r_nb_p <= NB_NOM;
        end else begin
            r_acc  <= w_acc_nxt;
            r_nb_p <= w_nb_p_nxt;
        end
    end

    assign o_nb_P = r_nb_p;

endmodule

// File: rtl/cdr_phase_ctrl.sv
// Early/late phase detector on three per-symbol samples, feeding a loop filter that trims the symbol period.
module cdr_phase_ctrl
    import cdr_pkg::*;
#(
    parameter int NB_P_NOM = cdr_pkg::NB_P_NOM,
    parameter int THRESH   = cdr_pkg::THRESH,
    parameter int ACC_W    = cdr_pkg::ACC_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_data,
    input  logic              i_en_d,
    input  logic              i_en_m,
    input  logic              i_en_f,
    input  logic              i_en,
    input  logic              i_en_freq_synch,
    output logic [NB_P_W-1:0] o_nb_P,
    output logic              o_bit,
    output logic              o_bit_valid,
    output logic              o_early,
    output logic              o_late
);

    logic    r_s_d, r_s_m, r_s_f;
    logic    r_bit, r_bit_valid, r_early, r_late;
    pd_dec_e w_dec;
    pd_dec_e w_dec_gated;

    // A transition inside the symbol lands on whichever half the middle sample disagrees with.
    always_comb begin
        w_dec = PD_NONE;
        if (r_s_d ^ r_s_f) begin
            w_dec = (r_s_m == r_s_f) ? PD_LATE : PD_EARLY;
        end
        w_dec_gated = i_en ? w_dec : PD_NONE;
    end

    // NOTE: synchronous reset is sampled only on the clock edge; it clears samples and pulses alike.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s_d       <= 1'b0;
            r_s_m       <= 1'b0;
            r_s_f       <= 1'b0;
            r_bit       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_early     <= 1'b0;
            r_late      <= 1'b0;
        end else begin
            if (i_en_d) r_s_d <= i_data;
            if (i_en_m) r_s_m <= i_data;
            if (i_en_f) r_s_f <= i_data;
            if (i_en)   r_bit <= r_s_m;
            r_bit_valid <= i_en;
            r_early     <= (w_dec_gated == PD_EARLY);
            r_late      <= (w_dec_gated == PD_LATE);
        end
    end

    cdr_loop_filter #(
        .NB_P_NOM (NB_P_NOM),
        .THRESH   (THRESH),
        .ACC_W    (ACC_W)
    ) u_loop_filter (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_dec           (w_dec_gated),
        .i_en_freq_synch (i_en_freq_synch),
        .o_nb_P          (o_nb_P)
    );

    assign o_bit       = r_bit;
    assign o_bit_valid = r_bit_valid;
    assign o_early     = r_early;
    assign o_late      = r_late;

endmodule

// File: doc/cdr_phase_ctrl.md
CDR_PHASE_CTRL -- requirements
Module: cdr_phase_ctrl

Interface
REQ-001 SHALL have parameter NB_P_NOM, default 25, nominal symbol period in clock cycles.
REQ-002 SHALL have parameter THRESH, default 4, accumulator magnitude that triggers a phase correction.
REQ-003 SHALL have parameter ACC_W, default 4, signed accumulator width.
REQ-004 SHALL have ports, one per line (clock and reset first):
- i_clk  input  1  sole clock
- i_rst  input  1  synchronous, active-high reset
- i_data  input  1  oversampled serial data, already synchronised to i_clk
- i_en_d  input  1  strobe: sample at start of symbol
- i_en_m  input  1  strobe: sample at middle of symbol
- i_en_f  input  1  strobe: sample at end of symbol
- i_en  input  1  strobe: evaluate phase decision
- i_en_freq_synch  input  1  strobe: period-update point
- o_nb_P  output  6  symbol period returned to the strobe counter
- o_bit  output  1  recovered bit
- o_bit_valid  output  1  one-cycle pulse qualifying o_bit
- o_early  output  1  one-cycle pulse: sampling early
- o_late  output  1  one-cycle pulse: sampling late

Function
REQ-005 SHALL register i_data into s_d, s_m, s_f on the cycle its strobe is high; coincident strobes SHALL each capture the same i_data.
REQ-006 On i_en SHALL compute T = s_d XOR s_f (transition within symbol).
REQ-007 T=1 and s_m==s_f: transition between start and middle SHALL be a LATE decision.
REQ-008 T=1 and s_m==s_d: transition between middle and end SHALL be an EARLY decision.
REQ-009 T=0 (including glitch case s_d==s_f!=s_m) SHALL be a NONE decision with no accumulator change.
REQ-010 o_bit SHALL equal s_m and o_bit_valid SHALL pulse for one cycle, registered one cycle after i_en.
REQ-011 o_early/o_late SHALL pulse for one cycle, one cycle after i_en, never both high.
REQ-012 Accumulator acc (signed ACC_W) SHALL add +1 on EARLY and -1 on LATE, saturating at +/-(2^(ACC_W-1)-1).
REQ-013 On i_en_freq_synch: if acc >= THRESH, o_nb_P SHALL become NB_P_NOM+1 and acc SHALL clear to 0; if acc <= -THRESH, o_nb_P SHALL become NB_P_NOM-1 and acc SHALL clear to 0; otherwise o_nb_P SHALL become NB_P_NOM and acc SHALL hold.
REQ-014 o_nb_P SHALL update on the cycle after i_en_freq_synch and hold until the next i_en_freq_synch, so a correction lasts exactly one symbol.
REQ-015 If i_en and i_en_freq_synch coincide, the threshold check SHALL use acc after the i_en update.
REQ-016 Strobes arriving with no prior i_en_d/m/f in the symbol SHALL use the last held sample values.

Reset
REQ-017 While i_rst=1: s_d/s_m/s_f=0, acc=0, o_nb_P=NB_P_NOM, o_bit=0, o_bit_valid=0, o_early=0, o_late=0; all strobes ignored.
REQ-018 Reset asserted mid-symbol SHALL discard partial samples; the first decision after release SHALL use only samples captured after release.

Structure
REQ-019 Package cdr_pkg SHALL hold NB_P_W=6, NB_P_NOM, THRESH, ACC_W and the enum pd_dec_e {PD_NONE, PD_EARLY, PD_LATE}.
REQ-020 The accumulator and period-select logic SHALL be a sub-module cdr_loop_filter, taking pd_dec_e plus i_en_freq_synch and returning o_nb_P.

Verification
REQ-021 Data 0->1 transition between i_en_d and i_en_m (s_d=0, s_m=1, s_f=1) -> o_late pulse one cycle after i_en, o_bit=1, acc=-1.
REQ-022 Four consecutive EARLY symbols -> at the 4th i_en_freq_synch o_nb_P=26 for one symbol, then 25; acc=0.
REQ-023 Four consecutive LATE symbols -> o_nb_P=24 for one symbol, then 25.
REQ-024 Constant data 1 for 10 symbols -> no o_early/o_late, o_bit=1 with 10 valid pulses, o_nb_P stays 25.
REQ-025 i_en and i_en_freq_synch in the same cycle with acc=3 and an EARLY decision -> o_nb_P=26 on the next cycle.
REQ-026 Reset asserted with acc=3 and o_nb_P=24 -> next cycle acc=0, o_nb_P=25, all pulses low.
